// File: rtl/multiplier_pkg.sv
// Shared definitions for the byte-sliced RV32M multiplier controller:
// funct3 encodings, FSM state encoding, lane count and the lane shift-code
// lookup used while rotating operand B.
package multiplier_pkg;

   localparam int unsigned NUM_LANES = 4;

   typedef enum logic [2:0] {
      F3_MUL    = 3'b000,
      F3_MULH   = 3'b001,
      F3_MULHSU = 3'b010,
      F3_MULHU  = 3'b011
   } funct3_e;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACC   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_e;

   // Byte weight of lane k in round r: lane k holds A byte k times original
   // B byte j = (k - r) mod 4, so the product lands at byte position k + j.
   function automatic logic [2:0] shift_code(input logic [1:0] k, input logic [1:0] r);
      logic [1:0] j;
      j = k - r;  // two-bit wrap gives the mod-4 lane index
      return {1'b0, k} + {1'b0, j};
   endfunction

endpackage

// File: rtl/mul_ctrl_delay.sv
// Register line that delays the accumulate enable and lane shift codes by
// DEPTH cycles so they arrive with the pipelined lane products. DEPTH = 0
// degenerates to a wire. A synchronous flush empties every stage.
module mul_ctrl_delay #(
   parameter int unsigned DEPTH = 1,
   parameter int unsigned WIDTH = 13
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             flush_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   generate
      if (DEPTH == 0) begin : g_bypass
         logic unused_bypass;
         assign unused_bypass = ^{clk_i, rst_ni, flush_i};
         assign q_o = d_i;
      end else begin : g_line
         logic [WIDTH-1:0] line_q [DEPTH];
         logic [WIDTH-1:0] line_d [DEPTH];

         // Next value of each stage: shift toward the output, or clear on flush
         always_comb begin
            line_d[0] = flush_i ? '0 : d_i;
            for (int i = 1; i < DEPTH; i++) begin
               line_d[i] = flush_i ? '0 : line_q[i-1];
            end
         end

         // Stage registers
         // NOTE: these are a few control flops, not a datapath memory, so every
         // stage is reset; a stale accumulate enable after reset would corrupt
         // the next result.
         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               for (int i = 0; i < DEPTH; i++) line_q[i] <= '0;
            end else begin
               for (int i = 0; i < DEPTH; i++) line_q[i] <= line_d[i];
            end
         end

         assign q_o = line_q[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/multiplier_ctrl.sv
// Control FSM for the byte-sliced RV32M multiplier: accepts a MUL-family
// request, loads the operands, runs four rotate-and-accumulate rounds,
// drains the lane pipeline and holds the result until it is taken.
// Optional build macro MUL_ZERO_SKIP_EN: adds op_A_zero_i/op_B_zero_i and
// finishes a zero-operand multiply straight after the load cycle.
module multiplier_ctrl
   import multiplier_pkg::*;
#(
   parameter int unsigned PIPE_DEPTH = 1
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       start_i,
   input  logic [2:0] funct3_i,
   output logic       ready_o,
   input  logic       kill_i,
   output logic       valid_o,
   input  logic       ready_i,
`ifdef MUL_ZERO_SKIP_EN
   input  logic       op_A_zero_i,
   input  logic       op_B_zero_i,
`endif
   output logic       res_hi_o,
   output logic       reg_A_en_o,
   output logic       reg_B_en_o,
   output logic       AC_en_o,
   output logic       ac_clr_o,
   output logic       mux_B_sel_o,
   output logic       rol_en_o,
   output logic       signed_A_o,
   output logic [3:0] sig_ctrl_B_o,
   output logic [2:0] shift_0_o,
   output logic [2:0] shift_1_o,
   output logic [2:0] shift_2_o,
   output logic [2:0] shift_3_o
);

   localparam logic [1:0]  DRAIN_LAST = 2'((PIPE_DEPTH == 0) ? 0 : PIPE_DEPTH - 1);
   localparam int unsigned DLY_W      = 1 + 3 * NUM_LANES;

   state_e     state_q, state_d;
   logic [1:0] r_q, r_d;
   logic       sa_q, sa_d;
   logic       sb_q, sb_d;
   logic       hi_q, hi_d;

   logic       accept;
   logic       zero_skip;
   logic       ac_en_mul;
   logic [2:0] shift_mul [NUM_LANES];
   logic [DLY_W-1:0] dly_in, dly_out;

`ifdef MUL_ZERO_SKIP_EN
   assign zero_skip = op_A_zero_i | op_B_zero_i;
`else
   assign zero_skip = 1'b0;
`endif

   // Divide encodings (funct3[2] set) are not ours and are never accepted.
   assign accept = (state_q == S_IDLE) & start_i & ~kill_i & ~funct3_i[2];

   // State, round counter and latched operation flags
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples its pre-edge value regardless of statement order.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         r_q     <= '0;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         hi_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         hi_q    <= hi_d;
      end
   end

   // Next state and undelayed (Mealy) datapath controls
   // NOTE: every output gets a default before the case so no path leaves a
   // signal unassigned, which would infer a latch.
   always_comb begin
      state_d      = state_q;
      r_d          = r_q;
      sa_d         = sa_q;
      sb_d         = sb_q;
      hi_d         = hi_q;
      ready_o      = 1'b0;
      reg_A_en_o   = 1'b0;
      reg_B_en_o   = 1'b0;
      mux_B_sel_o  = 1'b0;
      rol_en_o     = 1'b0;
      ac_clr_o     = 1'b0;
      signed_A_o   = 1'b0;
      sig_ctrl_B_o = 4'b0000;
      valid_o      = 1'b0;
      res_hi_o     = 1'b0;
      ac_en_mul    = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            ready_o = 1'b1;
            if (accept) begin
               reg_A_en_o = 1'b1;
               reg_B_en_o = 1'b1;
               ac_clr_o   = 1'b1;
               sa_d       = (funct3_i == F3_MULH) | (funct3_i == F3_MULHSU);
               sb_d       = (funct3_i == F3_MULH);
               hi_d       = (funct3_i != F3_MUL);
               r_d        = '0;
               state_d    = zero_skip ? S_DONE : S_ACC;
            end
         end
         S_ACC: begin
            ac_en_mul  = 1'b1;
            signed_A_o = sa_q;
            // Lane (r+3) mod 4 holds original B byte 3, the only signed byte.
            if (sb_q) sig_ctrl_B_o = 4'b0001 << (r_q + 2'd3);
            if (r_q != 2'd3) begin
               reg_B_en_o  = 1'b1;
               mux_B_sel_o = 1'b1;
               rol_en_o    = 1'b1;
               r_d         = r_q + 2'd1;
            end else begin
               r_d     = '0;
               state_d = (PIPE_DEPTH == 0) ? S_DONE : S_DRAIN;
            end
         end
         S_DRAIN: begin
            // r_q is reused to count drain cycles.
            if (r_q == DRAIN_LAST) begin
               r_d     = '0;
               state_d = S_DONE;
            end else begin
               r_d = r_q + 2'd1;
            end
         end
         S_DONE: begin
            valid_o  = 1'b1;
            res_hi_o = hi_q;
            if (ready_i) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (kill_i) begin
         state_d = S_IDLE;
         r_d     = '0;
      end
   end

   // Multiply-stage shift codes for the current rotation round
   always_comb begin
      for (int k = 0; k < NUM_LANES; k++) begin
         shift_mul[k] = (state_q == S_ACC) ? shift_code(2'(k), r_q) : 3'd0;
      end
   end

   assign dly_in = {ac_en_mul, shift_mul[0], shift_mul[1], shift_mul[2], shift_mul[3]};

   mul_ctrl_delay #(
      .DEPTH (PIPE_DEPTH),
      .WIDTH (DLY_W)
   ) u_delay (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .flush_i (kill_i),
      .d_i     (dly_in),
      .q_o     (dly_out)
   );

   // A kill must stop accumulation in the very cycle it arrives.
   assign AC_en_o   = dly_out[12] & ~kill_i;
   assign shift_0_o = dly_out[11:9];
   assign shift_1_o = dly_out[8:6];
   assign shift_2_o = dly_out[5:3];
   assign shift_3_o = dly_out[2:0];

endmodule

// File: tb/tb_multiplier_ctrl.sv
// Self-checking bench for multiplier_ctrl. A timeline model (cycles elapsed
// since accept) predicts every output each cycle. Honours MUL_ZERO_SKIP_EN.
module tb_multiplier_ctrl;

   localparam int unsigned PIPE = 1;

   logic       clk_i = 1'b0;
   logic       rst_ni;
   logic       start_i;
   logic [2:0] funct3_i;
   logic       ready_o;
   logic       kill_i;
   logic       valid_o;
   logic       ready_i;
   logic       res_hi_o;
   logic       reg_A_en_o, reg_B_en_o, AC_en_o, ac_clr_o, mux_B_sel_o, rol_en_o;
   logic       signed_A_o;
   logic [3:0] sig_ctrl_B_o;
   logic [2:0] shift_0_o, shift_1_o, shift_2_o, shift_3_o;
`ifdef MUL_ZERO_SKIP_EN
   logic       op_A_zero_i, op_B_zero_i;
`endif

   int n_cmp = 0;
   int n_err = 0;

   // Model state: active operation, cycles since its accept, latched op flags.
   bit m_act  = 1'b0;
   int m_age  = 0;
   bit m_sa   = 1'b0;
   bit m_sb   = 1'b0;
   bit m_hi   = 1'b0;
   bit m_skip = 1'b0;

   always #5 clk_i = ~clk_i;

   multiplier_ctrl #(.PIPE_DEPTH(PIPE)) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .start_i      (start_i),
      .funct3_i     (funct3_i),
      .ready_o      (ready_o),
      .kill_i       (kill_i),
      .valid_o      (valid_o),
      .ready_i      (ready_i),
`ifdef MUL_ZERO_SKIP_EN
      .op_A_zero_i  (op_A_zero_i),
      .op_B_zero_i  (op_B_zero_i),
`endif
      .res_hi_o     (res_hi_o),
      .reg_A_en_o   (reg_A_en_o),
      .reg_B_en_o   (reg_B_en_o),
      .AC_en_o      (AC_en_o),
      .ac_clr_o     (ac_clr_o),
      .mux_B_sel_o  (mux_B_sel_o),
      .rol_en_o     (rol_en_o),
      .signed_A_o   (signed_A_o),
      .sig_ctrl_B_o (sig_ctrl_B_o),
      .shift_0_o    (shift_0_o),
      .shift_1_o    (shift_1_o),
      .shift_2_o    (shift_2_o),
      .shift_3_o    (shift_3_o)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic bit zero_in();
`ifdef MUL_ZERO_SKIP_EN
      return op_A_zero_i | op_B_zero_i;
`else
      return 1'b0;
`endif
   endfunction

   function automatic bit exp_accept();
      return !m_act && start_i && !kill_i && !funct3_i[2];
   endfunction

   function automatic bit exp_valid();
      return m_act && (m_skip || m_age >= int'(PIPE) + 5);
   endfunction

   // Compare every DUT output against the model for the present cycle.
   task automatic compare_all();
      bit         acc, in_ac, e_rol, e_ac, acc_now;
      int         r, rr;
      logic [3:0] e_sig;
      logic [2:0] e_sh [4];
      logic [2:0] got_sh [4];
      acc_now = exp_accept();
      acc     = m_act && !m_skip && m_age >= 1 && m_age <= 4;
      r       = m_age - 1;
      e_rol   = acc && r < 3;
      e_sig   = (acc && m_sb) ? 4'(1 << ((r + 3) % 4)) : 4'b0000;
      rr      = m_age - int'(PIPE) - 1;
      in_ac   = m_act && !m_skip && rr >= 0 && rr <= 3;
      e_ac    = in_ac && !kill_i;
      for (int k = 0; k < 4; k++) e_sh[k] = in_ac ? 3'(k + ((k - rr + 4) % 4)) : 3'd0;
      got_sh[0] = shift_0_o; got_sh[1] = shift_1_o;
      got_sh[2] = shift_2_o; got_sh[3] = shift_3_o;

      check("ready_o",     32'(ready_o),      32'(!m_act));
      check("reg_A_en_o",  32'(reg_A_en_o),   32'(acc_now));
      check("reg_B_en_o",  32'(reg_B_en_o),   32'(acc_now || e_rol));
      check("ac_clr_o",    32'(ac_clr_o),     32'(acc_now));
      check("mux_B_sel_o", 32'(mux_B_sel_o),  32'(e_rol));
      check("rol_en_o",    32'(rol_en_o),     32'(e_rol));
      check("signed_A_o",  32'(signed_A_o),   32'(acc && m_sa));
      check("sig_ctrl_B",  32'(sig_ctrl_B_o), 32'(e_sig));
      check("AC_en_o",     32'(AC_en_o),      32'(e_ac));
      for (int k = 0; k < 4; k++) check($sformatf("shift_%0d_o", k), 32'(got_sh[k]), 32'(e_sh[k]));
      check("valid_o",     32'(valid_o),      32'(exp_valid()));
      check("res_hi_o",    32'(res_hi_o),     32'(exp_valid() && m_hi));
      check("clr_and_acen", 32'(ac_clr_o & AC_en_o), 32'd0);
   endtask

   // Advance the model across one clock edge using the inputs seen at it.
   task automatic model_step();
      if (kill_i) begin
         m_act = 1'b0;
      end else if (!m_act) begin
         if (exp_accept()) begin
            m_act  = 1'b1;
            m_age  = 1;
            m_sa   = (funct3_i == 3'b001) || (funct3_i == 3'b010);
            m_sb   = (funct3_i == 3'b001);
            m_hi   = (funct3_i != 3'b000);
            m_skip = zero_in();
         end
      end else if (exp_valid()) begin
         if (ready_i) m_act = 1'b0;
      end else begin
         m_age++;
      end
   endtask

   // One clock cycle: apply inputs, check at the falling edge, step the model.
   task automatic run(input logic st, input logic [2:0] f3, input logic rdy, input logic kl);
      start_i  = st;
      funct3_i = f3;
      ready_i  = rdy;
      kill_i   = kl;
      @(negedge clk_i);
      compare_all();
      @(posedge clk_i);
      model_step();
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) run(1'b0, 3'b000, 1'b1, 1'b0);
   endtask

   initial begin
      rst_ni   = 1'b0;
      start_i  = 1'b0;
      funct3_i = 3'b000;
      kill_i   = 1'b0;
      ready_i  = 1'b0;
`ifdef MUL_ZERO_SKIP_EN
      op_A_zero_i = 1'b0;
      op_B_zero_i = 1'b0;
`endif
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      compare_all();              // reset state
      rst_ni = 1'b1;
      @(posedge clk_i);
      #1;

      // MUL, MULH, MULHU, full latency, consumer always ready
      run(1'b1, 3'b000, 1'b1, 1'b0); idle(8);
      run(1'b1, 3'b001, 1'b1, 1'b0); idle(8);
      run(1'b1, 3'b011, 1'b1, 1'b0); idle(8);

      // MULHSU with the consumer stalled; start_i held high meanwhile
      run(1'b1, 3'b010, 1'b0, 1'b0);
      for (int i = 0; i < 5 + PIPE; i++) run(1'b0, 3'b000, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) run(1'b1, 3'b000, 1'b0, 1'b0);
      run(1'b1, 3'b000, 1'b1, 1'b0);   // handshake; not accepted here
      run(1'b1, 3'b000, 1'b1, 1'b0);   // accepted now
      idle(8);

      // Kill during ACC round 2, then an immediate new MUL
      run(1'b1, 3'b000, 1'b1, 1'b0);
      idle(2);
      run(1'b0, 3'b000, 1'b1, 1'b1);
      run(1'b1, 3'b000, 1'b1, 1'b0);
      idle(8);

      // Divide encoding ignored
      run(1'b1, 3'b100, 1'b1, 1'b0);
      run(1'b1, 3'b111, 1'b1, 1'b0);
      idle(2);

      // Asynchronous reset in the middle of ACC
      run(1'b1, 3'b001, 1'b1, 1'b0);
      idle(2);
      start_i = 1'b0;
      rst_ni  = 1'b0;
      #2;
      m_act = 1'b0;
      compare_all();
      @(negedge clk_i);
      compare_all();
      rst_ni = 1'b1;
      @(posedge clk_i);
      #1;
      idle(3);

`ifdef MUL_ZERO_SKIP_EN
      // Zero operand skips straight to DONE
      op_B_zero_i = 1'b1;
      run(1'b1, 3'b001, 1'b1, 1'b0);
      op_B_zero_i = 1'b0;
      idle(4);
`endif

      // Randomized traffic
      for (int i = 0; i < 800; i++) begin
`ifdef MUL_ZERO_SKIP_EN
         op_A_zero_i = ($urandom_range(0, 15) == 0);
         op_B_zero_i = ($urandom_range(0, 15) == 0);
`endif
         run(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
             1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 39) == 0));
      end
      idle(10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
